// File: rtl/id_ex_register.sv
// ID/EX pipeline register of the 5-stage RV32I core.
// Captures decoded operands and control from ID every cycle and presents them to EX.
// A taken-branch flush or a load-use stall replaces the captured instruction with an
// all-zero bubble. Saturating counters record how many bubbles of each kind were inserted.
module id_ex_register #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             enable_nop_mux,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [SIZE-1:0]  id_pc,
    input  logic [SIZE-1:0]  id_rs1_data,
    input  logic [SIZE-1:0]  id_rs2_data,
    input  logic [SIZE-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic [3:0]       id_alu_op,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_src,
    input  logic             id_branch,
    output logic             ex_valid,
    output logic [SIZE-1:0]  ex_pc,
    output logic [SIZE-1:0]  ex_rs1_data,
    output logic [SIZE-1:0]  ex_rs2_data,
    output logic [SIZE-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic [3:0]       ex_alu_op,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic [4:0]       ex_register_rd,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            insert_bubble;
    logic            next_valid;
    logic [SIZE-1:0] next_pc;
    logic [SIZE-1:0] next_rs1_data;
    logic [SIZE-1:0] next_rs2_data;
    logic [SIZE-1:0] next_imm;
    logic [4:0]      next_rs1;
    logic [4:0]      next_rs2;
    logic [4:0]      next_rd;
    logic [2:0]      next_funct3;
    logic [3:0]      next_alu_op;
    logic            next_reg_write;
    logic            next_mem_read;
    logic            next_mem_write;
    logic            next_mem_to_reg;
    logic            next_alu_src;
    logic            next_branch;

    assign insert_bubble = flush | enable_nop_mux;

    // Select the value captured at the next edge: an all-zero bubble or the gated ID fields.
    always_comb begin
        next_valid      = 1'b0;
        next_pc         = '0;
        next_rs1_data   = '0;
        next_rs2_data   = '0;
        next_imm        = '0;
        next_rs1        = '0;
        next_rs2        = '0;
        next_rd         = '0;
        next_funct3     = '0;
        next_alu_op     = '0;
        next_reg_write  = 1'b0;
        next_mem_read   = 1'b0;
        next_mem_write  = 1'b0;
        next_mem_to_reg = 1'b0;
        next_alu_src    = 1'b0;
        next_branch     = 1'b0;
        if (!insert_bubble) begin
            next_valid      = id_valid;
            next_pc         = id_pc;
            next_rs1_data   = id_rs1_data;
            next_rs2_data   = id_rs2_data;
            next_imm        = id_imm;
            next_rs1        = id_rs1;
            next_rs2        = id_rs2;
            next_rd         = id_rd;
            next_funct3     = id_funct3;
            next_alu_op     = id_alu_op;
            next_alu_src    = id_alu_src;
            next_reg_write  = id_valid & id_reg_write & (id_rd != 5'd0);
            next_mem_read   = id_valid & id_mem_read;
            next_mem_write  = id_valid & id_mem_write;
            next_mem_to_reg = id_valid & id_mem_to_reg;
            next_branch     = id_valid & id_branch;
        end
    end

    // Pipeline register: loads every cycle, cleared asynchronously by reset.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            ex_rs1_data    <= '0;
            ex_rs2_data    <= '0;
            ex_imm         <= '0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_rd          <= '0;
            ex_funct3      <= '0;
            ex_alu_op      <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_branch      <= 1'b0;
            ex_register_rd <= '0;
        end else begin
            ex_valid       <= next_valid;
            ex_pc          <= next_pc;
            ex_rs1_data    <= next_rs1_data;
            ex_rs2_data    <= next_rs2_data;
            ex_imm         <= next_imm;
            ex_rs1         <= next_rs1;
            ex_rs2         <= next_rs2;
            ex_rd          <= next_rd;
            ex_funct3      <= next_funct3;
            ex_alu_op      <= next_alu_op;
            ex_reg_write   <= next_reg_write;
            ex_mem_read    <= next_mem_read;
            ex_mem_write   <= next_mem_write;
            ex_mem_to_reg  <= next_mem_to_reg;
            ex_alu_src     <= next_alu_src;
            ex_branch      <= next_branch;
            ex_register_rd <= next_rd;
        end
    end

    // Saturating bubble counters; flush takes priority so a combined cycle counts once.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (flush) begin
            if (flush_count != CNT_MAX) begin
                flush_count <= flush_count + 1'b1;
            end
        end else if (enable_nop_mux) begin
            if (bubble_count != CNT_MAX) begin
                bubble_count <= bubble_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register with a narrow counter to reach saturation quickly.
module tb_id_ex_register;

    localparam int SIZE  = 32;
    localparam int CNT_W = 4;
    localparam int OUTW  = 1 + 4 * SIZE + 15 + 3 + 4 + 6 + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             CLK = 1'b0;
    logic             RST_n;
    logic             enable_nop_mux, flush, id_valid;
    logic [SIZE-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [2:0]       id_funct3;
    logic [3:0]       id_alu_op;
    logic             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
    logic             ex_valid;
    logic [SIZE-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd, ex_register_rd;
    logic [2:0]       ex_funct3;
    logic [3:0]       ex_alu_op;
    logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
    logic [CNT_W-1:0] bubble_count, flush_count;

    logic [OUTW-1:0]  dut_vec, exp_vec;
    logic [CNT_W-1:0] exp_bubble, exp_flush;
    int errors = 0;
    int checks = 0;

    id_ex_register #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_n(RST_n), .enable_nop_mux(enable_nop_mux), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_alu_op(id_alu_op), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_register_rd(ex_register_rd),
        .bubble_count(bubble_count), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    assign dut_vec = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                      ex_funct3, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write,
                      ex_mem_to_reg, ex_alu_src, ex_branch, ex_register_rd};

    // Reference: a bubble is all zeros; otherwise copy ID, gating control on validity and rd.
    function automatic logic [OUTW-1:0] model_out();
        logic ok;
        if (flush || enable_nop_mux) return '0;
        ok = id_valid;
        return {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                id_funct3, id_alu_op, ok && id_reg_write && (id_rd != 0), ok && id_mem_read,
                ok && id_mem_write, ok && id_mem_to_reg, id_alu_src, ok && id_branch, id_rd};
    endfunction

    task automatic randomize_inputs();
        id_valid      = $urandom_range(0, 3) != 0;
        id_pc         = $urandom;
        id_rs1_data   = $urandom;
        id_rs2_data   = $urandom;
        id_imm        = $urandom;
        id_rs1        = 5'($urandom);
        id_rs2        = 5'($urandom);
        id_rd         = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        id_funct3     = 3'($urandom);
        id_alu_op     = 4'($urandom);
        id_reg_write  = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
        id_alu_src    = 1'($urandom);
        id_branch     = 1'($urandom);
    endtask

    // Predict the edge from the current inputs, then advance past it.
    task automatic tick();
        exp_vec = model_out();
        if (flush) begin
            if (exp_flush != CNT_MAX) exp_flush = exp_flush + 1'b1;
        end else if (enable_nop_mux) begin
            if (exp_bubble != CNT_MAX) exp_bubble = exp_bubble + 1'b1;
        end
        @(posedge CLK);
        #2;
    endtask

    task automatic apply_reset();
        RST_n = 1'b0;
        flush = 1'b0;
        enable_nop_mux = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        RST_n = 1'b1;
        exp_bubble = '0;
        exp_flush  = '0;
        exp_vec    = '0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        flush = 1'b0;
        enable_nop_mux = 1'b0;
        randomize_inputs();
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (dut_vec !== '0 || bubble_count !== 0 || flush_count !== 0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got %h b=%0d f=%0d expected all zero", dut_vec, bubble_count, flush_count);
        end
        RST_n = 1'b1;
        exp_bubble = '0;
        exp_flush  = '0;
        enable_nop_mux = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        enable_nop_mux = 1'b0;
        randomize_inputs();
        id_valid = 1'b1;
        id_pc    = 32'hDEAD_BEE0;
        id_rd    = 5'd9;
        tick();
        checks++;
        if (dut_vec !== exp_vec || bubble_count !== 1 || flush_count !== 1) begin
            errors++;
            $display("[TB] FAIL reset_preload: got %h b=%0d f=%0d expected %h b=1 f=1", dut_vec, bubble_count, flush_count, exp_vec);
        end
        #1 RST_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0 || bubble_count !== 0 || flush_count !== 0) begin
            errors++;
            $display("[TB] FAIL reset_async: got %h b=%0d f=%0d expected all zero", dut_vec, bubble_count, flush_count);
        end
        #1 RST_n = 1'b1;
        exp_bubble = '0;
        exp_flush  = '0;
    endtask

    task automatic test_pass_through();
        randomize_inputs();
        id_pc = 32'h100;
        id_rd = 5'd5;
        id_mem_read = 1'b1;
        id_valid = 1'b1;
        tick();
        checks++;
        if (ex_pc !== 32'h100 || ex_register_rd !== 5'd5 || ex_mem_read !== 1'b1 || ex_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pass_through_fields: got pc=%h rd=%0d mr=%b v=%b expected pc=100 rd=5 mr=1 v=1", ex_pc, ex_register_rd, ex_mem_read, ex_valid);
        end
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++;
            $display("[TB] FAIL pass_through_vec: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_load_use();
        randomize_inputs();
        id_valid = 1'b1;
        id_rd = 5'd7;
        id_reg_write = 1'b1;
        enable_nop_mux = 1'b1;
        tick();
        enable_nop_mux = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_register_rd !== 5'd0 || dut_vec !== '0) begin
            errors++;
            $display("[TB] FAIL load_use_bubble: got %h expected all zero", dut_vec);
        end
        checks++;
        if (bubble_count !== 1 || flush_count !== 0) begin
            errors++;
            $display("[TB] FAIL load_use_count: got b=%0d f=%0d expected b=1 f=0", bubble_count, flush_count);
        end
    endtask

    task automatic test_flush_and_nop();
        randomize_inputs();
        id_valid = 1'b1;
        flush = 1'b1;
        enable_nop_mux = 1'b1;
        tick();
        flush = 1'b0;
        enable_nop_mux = 1'b0;
        checks++;
        if (dut_vec !== '0 || flush_count !== 1 || bubble_count !== 1) begin
            errors++;
            $display("[TB] FAIL flush_and_nop: got %h b=%0d f=%0d expected zero b=1 f=1", dut_vec, bubble_count, flush_count);
        end
    endtask

    task automatic test_rd_zero();
        randomize_inputs();
        id_valid = 1'b1;
        id_rd = 5'd0;
        id_reg_write = 1'b1;
        id_mem_read = 1'b1;
        tick();
        checks++;
        if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b1 || dut_vec !== exp_vec) begin
            errors++;
            $display("[TB] FAIL rd_zero: got rw=%b mr=%b vec=%h expected rw=0 mr=1 vec=%h", ex_reg_write, ex_mem_read, dut_vec, exp_vec);
        end
        randomize_inputs();
        id_valid = 1'b0;
        id_rd = 5'd3;
        {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 5'b11111;
        tick();
        checks++;
        if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch} !== 5'b0 || dut_vec !== exp_vec) begin
            errors++;
            $display("[TB] FAIL invalid_ctrl: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            randomize_inputs();
            flush = $urandom_range(0, 7) == 0;
            enable_nop_mux = $urandom_range(0, 5) == 0;
            tick();
            checks++;
            if (dut_vec !== exp_vec || bubble_count !== exp_bubble || flush_count !== exp_flush) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %h b=%0d f=%0d expected %h b=%0d f=%0d", i, dut_vec, bubble_count, flush_count, exp_vec, exp_bubble, exp_flush);
            end
        end
        flush = 1'b0;
        enable_nop_mux = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        enable_nop_mux = 1'b1;
        for (int i = 0; i < 20; i++) begin
            randomize_inputs();
            tick();
            checks++;
            if (bubble_count !== exp_bubble || dut_vec !== '0) begin
                errors++;
                $display("[TB] FAIL nop_sat[%0d]: got b=%0d vec=%h expected b=%0d zero", i, bubble_count, dut_vec, exp_bubble);
            end
        end
        checks++;
        if (bubble_count !== 4'd15 || flush_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL nop_sat_final: got b=%0d f=%0d expected b=15 f=0", bubble_count, flush_count);
        end
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enable_nop_mux = 1'($urandom);
            tick();
        end
        flush = 1'b0;
        enable_nop_mux = 1'b0;
        checks++;
        if (flush_count !== 4'd15 || bubble_count !== 4'd15) begin
            errors++;
            $display("[TB] FAIL flush_sat_final: got b=%0d f=%0d expected b=15 f=15", bubble_count, flush_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            id_valid = 1'b1;
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        RST_n = 1'b0;
        flush = 1'b0;
        enable_nop_mux = 1'b0;
        exp_bubble = '0;
        exp_flush  = '0;
        exp_vec    = '0;
        randomize_inputs();
        test_reset();
        test_pass_through();
        test_load_use();
        test_flush_and_nop();
        test_rd_zero();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
